grn_attractor_ctrl: RTL and testbench

GRN_ATTRACTOR_CTRL -- requirements
Module: grn_attractor_ctrl

---
 rtl/grn_pkg.sv | 16 +
 rtl/grn_vec_cmp.sv | 12 +
 rtl/grn_attractor_ctrl.sv | 153 +++++++++++++++
 tb/tb_grn_attractor_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grn_pkg.sv
// Shared definitions for the GRN attractor controller: FSM state encoding and
// default counter width / step limit.
package grn_pkg;

  localparam int unsigned GRN_CNT_W     = 32;
  localparam int unsigned GRN_MAX_STEPS = 2**20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PERIOD = 3'd3,
    ST_DONE   = 3'd4
  } grn_state_e;

endpackage

// File: rtl/grn_vec_cmp.sv
// Equality compare of the tortoise (s0) and hare (s1) node state vectors.
module grn_vec_cmp #(
  parameter int N_NODES = 16
) (
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               vec_eq
);

  assign vec_eq = (s0_vec == s1_vec);

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Floyd tortoise/hare attractor finder for a gene regulatory network of N_NODES nodes.
// Optional step limit enabled by defining GRN_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for an initial state, in_ready=1
//   LOAD   | one-cycle reset_nos pulse loads init_state into every node
//   RUN    | tortoise and hare both stepping until their states meet
//   PERIOD | tortoise frozen, hare stepping until it returns to the tortoise
//   DONE   | result held on out_* until out_ready
module grn_attractor_ctrl
  import grn_pkg::*;
#(
  parameter int          N_NODES   = 16,
  parameter int          CNT_W     = GRN_CNT_W,
  parameter int unsigned MAX_STEPS = GRN_MAX_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_NODES-1:0] in_state,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_NODES-1:0] out_init,
  output logic [CNT_W-1:0]   out_meet,
  output logic [CNT_W-1:0]   out_period,
  output logic               out_timeout,
  output logic               busy
);

  grn_state_e state;
  logic       vec_eq;
  logic       limit_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  grn_vec_cmp #(.N_NODES(N_NODES)) u_cmp (
    .s0_vec (s0_vec),
    .s1_vec (s1_vec),
    .vec_eq (vec_eq)
  );

`ifdef GRN_TIMEOUT_EN
  localparam logic [CNT_W:0] STEP_LIM = (CNT_W+1)'(MAX_STEPS);

  logic             timeout_q;
  logic [CNT_W:0]   step_sum;

  // One extra bit so the sum of two saturated counters cannot wrap below the limit.
  assign step_sum  = {1'b0, out_meet} + {1'b0, out_period};
  assign limit_hit = (step_sum >= STEP_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      timeout_q <= 1'b0;
    end else if ((state == ST_RUN || state == ST_PERIOD) && limit_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign out_timeout = timeout_q;
`else
  assign limit_hit   = 1'b0;
  assign out_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      reset_nos  <= 1'b0;
      start_s0   <= 1'b0;
      start_s1   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      init_state <= '0;
      out_init   <= '0;
      out_meet   <= '0;
      out_period <= '0;
    end else begin
      reset_nos <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            state      <= ST_LOAD;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            reset_nos  <= 1'b1;
            init_state <= in_state;
            out_init   <= in_state;
            out_meet   <= '0;
            out_period <= '0;
          end
        end
        ST_LOAD: begin
          state    <= ST_RUN;
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
        end
        ST_RUN: begin
          if (limit_hit) begin
            state     <= ST_DONE;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
            out_valid <= 1'b1;
          end else if (vec_eq && out_meet != '0) begin
            state    <= ST_PERIOD;
            start_s0 <= 1'b0;
          end else begin
            out_meet <= sat_inc(out_meet);
          end
        end
        ST_PERIOD: begin
          // The compare at out_period==0 sees the meeting point itself, so it is skipped.
          if (limit_hit || (vec_eq && out_period != '0)) begin
            state     <= ST_DONE;
            start_s1  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            out_period <= sat_inc(out_period);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          start_s0  <= 1'b0;
          start_s1  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Directed bench for grn_attractor_ctrl with a 4-node behavioural network;
// the step-limit scenario is built only when GRN_TIMEOUT_EN is defined.
module tb_grn_attractor_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_state;
  logic        reset_nos;
  logic [3:0]  init_state;
  logic        start_s0;
  logic        start_s1;
  logic [3:0]  s0_vec;
  logic [3:0]  s1_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_init;
  logic [31:0] out_meet;
  logic [31:0] out_period;
  logic        out_timeout;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_rn    = 0;
  int net_sel = 0;
  logic ph;

  always #5 clk = ~clk;

  grn_attractor_ctrl #(.N_NODES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .reset_nos   (reset_nos),
    .init_state  (init_state),
    .start_s0    (start_s0),
    .start_s1    (start_s1),
    .s0_vec      (s0_vec),
    .s1_vec      (s1_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_init    (out_init),
    .out_meet    (out_meet),
    .out_period  (out_period),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  // 0: identity, 1: rotate-left (period 4), 2: 3-bit counter in low bits (period 8)
  function automatic logic [3:0] net_f(input int sel, input logic [3:0] x);
    case (sel)
      1:       return {x[2:0], x[3]};
      2:       return {x[3], x[2:0] + 3'd1};
      default: return x;
    endcase
  endfunction

  // Hare steps on every pulse; tortoise steps on the 2nd, 4th, ... pulse after a load.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      ph     <= 1'b0;
    end else begin
      if (start_s1) s1_vec <= net_f(net_sel, s1_vec);
      if (start_s0) begin
        ph <= ~ph;
        if (ph) s0_vec <= net_f(net_sel, s0_vec);
      end
    end
  end

  always @(posedge clk) if (reset_nos) n_rn <= n_rn + 1;

`ifdef GRN_TIMEOUT_EN
  logic        in_valid2;
  logic        in_ready2;
  logic        reset_nos2;
  logic [3:0]  init_state2;
  logic        start_s0_2;
  logic        start_s1_2;
  logic [3:0]  s0_vec2;
  logic [3:0]  s1_vec2;
  logic        out_valid2;
  logic        out_ready2;
  logic [3:0]  out_init2;
  logic [31:0] out_meet2;
  logic [31:0] out_period2;
  logic        out_timeout2;
  logic        busy2;
  logic        ph2;

  grn_attractor_ctrl #(.N_NODES(4), .MAX_STEPS(8)) dut_to (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid2),
    .in_ready    (in_ready2),
    .in_state    (in_state),
    .reset_nos   (reset_nos2),
    .init_state  (init_state2),
    .start_s0    (start_s0_2),
    .start_s1    (start_s1_2),
    .s0_vec      (s0_vec2),
    .s1_vec      (s1_vec2),
    .out_valid   (out_valid2),
    .out_ready   (out_ready2),
    .out_init    (out_init2),
    .out_meet    (out_meet2),
    .out_period  (out_period2),
    .out_timeout (out_timeout2),
    .busy        (busy2)
  );

  always @(posedge clk) begin
    if (reset_nos2) begin
      s0_vec2 <= init_state2;
      s1_vec2 <= init_state2;
      ph2     <= 1'b0;
    end else begin
      if (start_s1_2) s1_vec2 <= net_f(2, s1_vec2);
      if (start_s0_2) begin
        ph2 <= ~ph2;
        if (ph2) s0_vec2 <= net_f(2, s0_vec2);
      end
    end
  end
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] st);
    in_state = st;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk(tag, out_valid, 1'b1);
  endtask

  initial begin
    logic [3:0] b2b_in [3];
    logic [3:0] b2b_out [3];
    bit         ok;
    int         rn0;
    int         idx;
    int         got;
    int         n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = 4'h0;
    out_ready = 1'b0;
`ifdef GRN_TIMEOUT_EN
    in_valid2  = 1'b0;
    out_ready2 = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctl", {out_valid, reset_nos, start_s0, start_s1}, 4'b0000);
    chk("rst_data", {init_state, out_init, out_timeout}, 9'h0);
    chk("rst_cnt", {out_meet, out_period}, 64'h0);

    // Identity network: fixed point, one RUN step and one PERIOD step.
    net_sel = 0;
    rn0 = n_rn;
    offer(4'b0101);
    chk("load_ctl", {in_ready, reset_nos, start_s0, start_s1, busy}, 5'b01001);
    chk("load_init_state", init_state, 4'b0101);
    tick();
    chk("run_ctl", {reset_nos, start_s0, start_s1}, 3'b011);
    wait_valid("id_wait_valid");
    chk("id_meet", out_meet, 32'd1);
    chk("id_period", out_period, 32'd1);
    chk("id_init", out_init, 4'b0101);
    chk("id_timeout", out_timeout, 1'b0);
    chk("done_starts", {reset_nos, start_s0, start_s1}, 3'b000);
    chk("id_one_load", n_rn - rn0, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Rotate-left from 0001: the hare leads by 4 after 7 RUN cycles, period 4.
    net_sel = 1;
    offer(4'b0001);
    wait_valid("rot_wait_valid");
    chk("rot_meet_ge1", (out_meet >= 1), 1'b1);
    chk("rot_meet", out_meet, 32'd7);
    chk("rot_period", out_period, 32'd4);
    chk("rot_init", out_init, 4'b0001);

    // Result held while out_ready is low; new offers must be ignored.
    rn0 = n_rn;
    in_state = 4'b1111;
    in_valid = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (out_meet !== 32'd7 || out_period !== 32'd4 || out_init !== 4'b0001 ||
          out_valid !== 1'b1 || in_ready !== 1'b0 || out_timeout !== 1'b0) ok = 1'b0;
    end
    chk("hold_stable", ok, 1'b1);
    chk("hold_no_load", n_rn - rn0, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_idle", {busy, in_ready, out_valid}, 3'b010);

    // Reset in the 3rd PERIOD cycle discards the run.
    net_sel = 1;
    offer(4'b0010);
    n = 0;
    while (!(start_s1 && !start_s0) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_period", {start_s1, start_s0}, 2'b10);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_starts", {reset_nos, start_s0, start_s1}, 3'b000);
    chk("midrst_cnt", {out_meet, out_period}, 64'h0);
    ok = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) ok = 1'b1;
    end
    chk("midrst_no_valid", ok, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);

    // 8-state counter: meet after 15 RUN cycles, period 8.
    net_sel = 2;
    offer(4'b1000);
    wait_valid("cnt_wait_valid");
    chk("cnt_meet", out_meet, 32'd15);
    chk("cnt_period", out_period, 32'd8);
    chk("cnt_timeout", out_timeout, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef GRN_TIMEOUT_EN
    // Step limit 8 stops the counter network before the hare catches up.
    in_state  = 4'b0000;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 100) begin
      tick();
      n++;
    end
    chk("to_wait_valid", out_valid2, 1'b1);
    chk("to_timeout", out_timeout2, 1'b1);
    chk("to_sum", out_meet2 + out_period2, 32'd8);
    chk("to_meet", out_meet2, 32'd8);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    chk("to_idle", {busy2, in_ready2}, 2'b01);
`endif

    // Back-to-back inputs with the result side always ready.
    net_sel   = 0;
    b2b_in[0] = 4'b0011;
    b2b_in[1] = 4'b1100;
    b2b_in[2] = 4'b1010;
    rn0 = n_rn;
    idx = 0;
    got = 0;
    ok  = 1'b1;
    in_state  = b2b_in[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (got < 3 && n < 300) begin
      bit acc;
      bit res;
      acc = in_valid && in_ready;
      res = out_valid && out_ready;
      if (res) begin
        b2b_out[got] = out_init;
        if (out_meet !== 32'd1 || out_period !== 32'd1) ok = 1'b0;
      end
      tick();
      n++;
      if (acc) begin
        idx++;
        if (idx < 3) in_state = b2b_in[idx];
        else in_valid = 1'b0;
      end
      if (res) got++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", got, 3);
    chk("b2b_accepted", idx, 3);
    chk("b2b_loads", n_rn - rn0, 3);
    chk("b2b_order", {b2b_out[0], b2b_out[1], b2b_out[2]}, {b2b_in[0], b2b_in[1], b2b_in[2]});
    chk("b2b_counts", ok, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
